reg_bank_arbiter: RTL and testbench
===================================

# reg_bank_arbiter

Shares one small register bank between two requesters using a registered request/grant handshake. Each request is a single write or read access. A two-state FSM serialises the accesses and a round-robin pointer resolves contention. The block sits between two independent register-based datapath stages and the common storage they both read and update.

## Interface
- WIDTH, 8, data width of each bank entry
- DEPTH, 4, number of bank entries; must be a power of two; AW = $clog2(DEPTH)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0, req1  in  1  access request from requester 0 / 1
- we0, we1  in  1  1 = write, 0 = read; qualified by reqN
- addr0, addr1  in  AW  entry address
- wdata0, wdata1  in  WIDTH  write data
- gnt0, gnt1  out  1  one-cycle pulse: requester N's access executes this cycle
- rdata  out  WIDTH  read data from the last read access
- rvalid  out  1  one-cycle pulse with the grant of a read
- busy  out  1  high while the FSM is in SERVE

## Operation
- FSM states:
  - IDLE: on the clock edge, if any reqN is high, select a winner, latch its we/addr/wdata into a command register and go to SERVE. Otherwise stay in IDLE.
  - SERVE: execute the latched command, assert gntN for the winner, update the pointer, and return to IDLE unconditionally.
- Round-robin:
  - A 1-bit last_winner register; reset value is 1, so requester 0 wins the first contention.
  - With both requests high, the requester that is not last_winner wins.
  - With one request high, that requester wins regardless of the pointer.
- Write: bank[addr] <= wdata at the end of SERVE. rvalid = 0 and rdata is unchanged.
- Read: rdata <= bank[addr] so that rdata is valid during SERVE; rvalid = 1 in the same cycle.
- Requester rule: hold reqN and the command stable until the edge at which gntN is sampled high, then drop reqN. A reqN still high in the following IDLE cycle counts as a new request.
- The loser's request stays pending and wins the next IDLE cycle.
- The command is latched at IDLE→SERVE, so input changes during SERVE have no effect on that access.
- Address width is exactly AW, so no out-of-range address is possible.

## Timing
- Reset values:
  - state = IDLE, last_winner = 1
  - gnt0 = gnt1 = 0, rvalid = 0, busy = 0
  - rdata = 0, all bank entries = 0
- Latency: request sampled at edge N → grant, rvalid and rdata high or valid during cycle N+1 → written data readable by a request sampled at edge N+2 or later.
- Throughput: at most one access per 2 cycles; under continuous contention the requesters alternate.
- gnt0 and gnt1 are never high together; busy equals (state == SERVE); all outputs are registered.
- Reset asserted during SERVE: the access is aborted, no write occurs, and no grant is issued. After release the FSM is in IDLE.

## Configuration
- ARB_FIXED_PRIO_EN:
  - Defined: requester 0 always wins contention; last_winner is not implemented.
  - Undefined (default): round-robin as described above.
  - Grant timing, handshake and reset behaviour are identical in both builds.

## Structure
- Package reg_arb_pkg:
  - state_t enum (IDLE, SERVE)
  - requester ID constants REQ0 = 1'b0, REQ1 = 1'b1
  - default WIDTH/DEPTH localparams
- Sub-module reg_bank: DEPTH × WIDTH storage with synchronous write, registered read and asynchronous reset to zero. The arbiter instantiates it once and drives it from the command register.

## Test plan
- Reset, then idle for 5 cycles → all outputs 0; busy stays 0.
- req0 write addr 2 data 0xA5, then req1 read addr 2 → gnt0 pulse; then gnt1 with rvalid = 1 and rdata = 0xA5.
- req0 and req1 both high from reset, held for 8 cycles, dropping reqN after each gntN and re-raising it in the next cycle → grants alternate 0,1,0,1 on every second cycle. With ARB_FIXED_PRIO_EN defined → only gnt0.
- req1 alone while last_winner = 1 → gnt1 granted on the next cycle; no starvation by the pointer.
- reset pulsed during SERVE of a write of 0x3C to addr 1 → a later read of addr 1 returns 0x00 and no grant is seen.
- Change wdata0 from 0x11 to 0x22 during SERVE → bank holds 0x11.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg
// Shared types and constants for the register bank arbiter.
//   state_t      : arbiter FSM states (IDLE, SERVE)
//   REQ0 / REQ1  : requester identifiers used for winner selection
//   DEF_WIDTH    : default bank entry width
//   DEF_DEPTH    : default number of bank entries (power of two)
package reg_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/reg_bank.sv
// reg_bank
// DEPTH x WIDTH register storage with one synchronous write port and one
// registered read port. All entries and the read register clear to zero on
// asynchronous reset.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   re     in  read enable; rdata only changes when re is high
//   raddr  in  read address
//   rdata  out registered read data
module reg_bank
  import reg_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // rdata holds its value between reads so a write never disturbs it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
// Shares one reg_bank between two requesters. An IDLE/SERVE FSM executes one
// access every two cycles; contention is resolved round-robin through a
// one-bit last_winner pointer.
// Configuration macro: ARB_FIXED_PRIO_EN
//   defined   -> requester 0 always wins contention, no pointer
//   undefined -> round-robin (default)
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   req0/req1         access requests
//   we0/we1           1 = write, 0 = read
//   addr0/addr1       entry addresses
//   wdata0/wdata1     write data
//   gnt0/gnt1         one-cycle pulse while the requester's access executes
//   rdata             data of the last read access
//   rvalid            one-cycle pulse alongside the grant of a read
//   busy              high while the FSM is in SERVE
module reg_bank_arbiter
  import reg_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             busy
);

  state_t state, state_next;

  logic             start;
  logic             winner;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_wdata;

  logic             cmd_we;
  logic [AW-1:0]    cmd_addr;
  logic [WIDTH-1:0] cmd_wdata;

`ifndef ARB_FIXED_PRIO_EN
  logic last_winner;

  // Pointer moves to whoever is being served; gnt1 identifies that requester
  // during SERVE. Reset value 1 lets requester 0 win the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_winner <= REQ1;
    end else if (state == SERVE) begin
      last_winner <= gnt1;
    end
  end
`endif

  // Winner selection and input mux. A lone request always wins; only true
  // contention consults the pointer (or fixed priority).
  always_comb begin
    winner = REQ0;
    if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
      winner = REQ0;
`else
      winner = ~last_winner;
`endif
    end else if (req1) begin
      winner = REQ1;
    end
    sel_we    = (winner == REQ1) ? we1    : we0;
    sel_addr  = (winner == REQ1) ? addr1  : addr0;
    sel_wdata = (winner == REQ1) ? wdata1 : wdata0;
  end

  assign start = (state == IDLE) && (req0 || req1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req0 || req1) state_next = SERVE;
      SERVE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command register: frozen at IDLE->SERVE so input changes during SERVE
  // cannot affect the access being executed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (start) begin
      cmd_we    <= sel_we;
      cmd_addr  <= sel_addr;
      cmd_wdata <= sel_wdata;
    end
  end

  // Handshake outputs are registered at the same edge that enters SERVE, so
  // they are high exactly for the SERVE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      rvalid <= 1'b0;
      busy   <= 1'b0;
    end else begin
      gnt0   <= start && (winner == REQ0);
      gnt1   <= start && (winner == REQ1);
      rvalid <= start && !sel_we;
      busy   <= start;
    end
  end

  // The read is issued at the IDLE->SERVE edge so rdata is valid during SERVE;
  // the write commits at the SERVE->IDLE edge from the command register.
  reg_bank #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .we    ((state == SERVE) && cmd_we),
    .waddr (cmd_addr),
    .wdata (cmd_wdata),
    .re    (start && !sel_we),
    .raddr (sel_addr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter
// Scoreboard bench for reg_bank_arbiter: the driver issues request rounds and
// a transaction-level model pushes the expected grant sequence; a negedge
// monitor pops and compares whenever a grant appears.
// Honours ARB_FIXED_PRIO_EN in its reference model.
module tb_reg_bank_arbiter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1, we0, we1;
  logic [AW-1:0]    addr0, addr1;
  logic [WIDTH-1:0] wdata0, wdata1;
  logic             gnt0, gnt1, rvalid, busy;
  logic [WIDTH-1:0] rdata;

  always #5 clk = ~clk;

  reg_bank_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata), .rvalid(rvalid), .busy(busy)
  );

  typedef struct {
    bit             id;
    bit             is_read;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] model_bank [DEPTH];
  bit               model_last;
  logic [WIDTH-1:0] model_rdata;
  int               tests = 0;
  int               fails = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_bank[i] = '0;
    model_last  = 1'b1;
    model_rdata = '0;
    exp_q.delete();
  endtask

  // One access in arbitration order: a read returns current bank contents,
  // a write leaves the read data untouched.
  task automatic model_access(input bit id, input bit we, input logic [AW-1:0] a,
                              input logic [WIDTH-1:0] d);
    exp_t e;
    e.id      = id;
    e.is_read = !we;
    if (we) model_bank[a] = d;
    else    model_rdata   = model_bank[a];
    e.data = model_rdata;
    exp_q.push_back(e);
    model_last = id;
  endtask

  // Monitor: compares every presented grant against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      checkOutput("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
      checkOutput("busy_matches_serve", {31'd0, busy}, {31'd0, gnt0 | gnt1});
      if (gnt0 || gnt1) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_grant", {30'd0, gnt0, gnt1}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("grant_id", {30'd0, gnt0, gnt1}, e.id ? 32'd1 : 32'd2);
          checkOutput("rvalid", {31'd0, rvalid}, {31'd0, e.is_read});
          checkOutput("rdata", {24'd0, rdata}, {24'd0, e.data});
        end
      end else begin
        checkOutput("rvalid_without_grant", {31'd0, rvalid}, 32'd0);
      end
    end
  end

  // Issue one round: both requesters present their command together, hold it
  // until their grant has been sampled, and scramble it while being served.
  task automatic applyStimulus(input bit r0, input bit r1,
                               input bit w0, input logic [AW-1:0] a0, input logic [WIDTH-1:0] d0,
                               input bit w1, input logic [AW-1:0] a1, input logic [WIDTH-1:0] d1);
    bit first;
    bit pend0, pend1, g0, g1;
    int cyc;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    if (r0 && r1) begin
`ifdef ARB_FIXED_PRIO_EN
      first = 1'b0;
`else
      first = !model_last;
`endif
      if (!first) begin
        model_access(1'b0, w0, a0, d0);
        model_access(1'b1, w1, a1, d1);
      end else begin
        model_access(1'b1, w1, a1, d1);
        model_access(1'b0, w0, a0, d0);
      end
    end else if (r0) begin
      model_access(1'b0, w0, a0, d0);
    end else if (r1) begin
      model_access(1'b1, w1, a1, d1);
    end
    pend0 = r0;
    pend1 = r1;
    cyc   = 0;
    while ((pend0 || pend1) && cyc < 20) begin
      @(negedge clk);
      cyc++;
      g0 = gnt0;
      g1 = gnt1;
      if (g0) begin wdata0 = wdata0 ^ 8'h33; addr0 = addr0 ^ 2'b01; end
      if (g1) begin wdata1 = wdata1 ^ 8'h33; addr1 = addr1 ^ 2'b01; end
      @(posedge clk);
      #1;
      if (g0) begin req0 = 1'b0; pend0 = 1'b0; end
      if (g1) begin req1 = 1'b0; pend1 = 1'b0; end
    end
    if (pend0 || pend1) begin
      checkOutput("round_timeout", {30'd0, pend0, pend1}, 32'd0);
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset: everything stays zero.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("idle_outputs", {20'd0, gnt0, gnt1, rvalid, busy, rdata}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Lone req1 with the pointer at 1 is still served.
    applyStimulus(0, 1, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);

    // Write 0xA5 to addr 2 from requester 0, read it back from requester 1.
    applyStimulus(1, 0, 1, 2'd2, 8'hA5, 0, 2'd0, 8'h00);
    applyStimulus(0, 1, 0, 2'd0, 8'h00, 0, 2'd2, 8'h00);

    // Continuous contention: grants alternate (only gnt0 first in fixed build).
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 1, 2'(i), 8'(8'h10 + i), 0, 2'(3 - i), 8'h00);
    end

    // Command changes during SERVE must not affect the executing write.
    applyStimulus(1, 0, 1, 2'd3, 8'h11, 0, 2'd0, 8'h00);
    applyStimulus(0, 1, 0, 2'd0, 8'h00, 0, 2'd3, 8'h00);
    applyStimulus(1, 0, 0, 2'd2, 8'h00, 0, 2'd0, 8'h00);

    // Randomised rounds.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom), 1'($urandom),
                    1'($urandom), 2'($urandom), 8'($urandom),
                    1'($urandom), 2'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_drained_pre_abort", exp_q.size(), 32'd0);

    // Reset pulsed during SERVE of a write: no grant, no write.
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; wdata0 = 8'h3C;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_no_grant", {28'd0, gnt0, gnt1, rvalid, busy}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req0  = 1'b0;
    model_reset();
    @(negedge clk);
    checkOutput("after_abort_idle", {20'd0, gnt0, gnt1, rvalid, busy, rdata}, 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(0, 1, 0, 2'd0, 8'h00, 0, 2'd1, 8'h00);
    applyStimulus(1, 1, 0, 2'd1, 8'h00, 1, 2'd0, 8'h77);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
